// File: rtl/mux_pipe.sv
// rtl/mux_pipe.sv - N-input registered mux with explicit/round-robin select (optional skid: MUX_PIPE_SKID_EN)
module mux_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_IN*WIDTH-1:0]  in_data,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_ready,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     rr_mode,
  output logic [WIDTH-1:0]         out_data,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_valid,
  input  logic                     out_ready
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] grant;
  logic             grant_ok;
  logic             can_accept;
  logic             accept;
  logic [WIDTH-1:0] grant_data;
  logic             out_drain;
  int               rr_idx;

  assign out_drain = out_valid && out_ready;

`ifdef MUX_PIPE_SKID_EN
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic [SEL_W-1:0] skid_sel;

  // With a skid entry available, acceptance never looks at out_ready
  assign can_accept = !skid_valid;
`else
  assign can_accept = !out_valid || out_ready;
`endif

  // Pick the eligible channel: sel in explicit mode, first requester after ptr in round-robin
  always_comb begin
    grant    = '0;
    grant_ok = 1'b0;
    rr_idx   = 0;
    if (!rr_mode) begin
      grant    = sel;
      grant_ok = (int'(sel) < NUM_IN);
    end else begin
      // Walk the search order backwards so the nearest requester wins last
      for (int i = NUM_IN; i >= 1; i--) begin
        rr_idx = (int'(ptr) + i) % NUM_IN;
        if (in_valid[rr_idx]) begin
          grant    = SEL_W'(rr_idx);
          grant_ok = 1'b1;
        end
      end
    end
  end

  // Only the granted channel sees ready, and only when the stage has room
  always_comb begin
    in_ready = '0;
    if (grant_ok && can_accept) begin
      in_ready[grant] = 1'b1;
    end
  end

  assign accept     = grant_ok && can_accept && in_valid[grant];
  assign grant_data = in_data[int'(grant)*WIDTH +: WIDTH];

  // Round-robin pointer advances to the winner only on an accepted rr transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= SEL_W'(NUM_IN - 1);
    end else if (accept && rr_mode) begin
      ptr <= grant;
    end
  end

`ifdef MUX_PIPE_SKID_EN
  // Output register plus one-entry skid; skid drains into the output first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_sel   <= '0;
    end else if (skid_valid) begin
      if (out_drain) begin
        out_data   <= skid_data;
        out_sel    <= skid_sel;
        skid_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!out_valid || out_drain) begin
        out_data  <= grant_data;
        out_sel   <= grant;
        out_valid <= 1'b1;
      end else begin
        skid_data  <= grant_data;
        skid_sel   <= grant;
        skid_valid <= 1'b1;
      end
    end else if (out_drain) begin
      out_valid <= 1'b0;
    end
  end
`else
  // Single output register: reload on accept, otherwise clear once drained
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (accept) begin
      out_data  <= grant_data;
      out_sel   <= grant;
      out_valid <= 1'b1;
    end else if (out_drain) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_mux_pipe.sv
// tb/tb_mux_pipe.sv - randomized queue-model bench for mux_pipe
module tb_mux_pipe;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int SW = 2;
`ifdef MUX_PIPE_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [SW-1:0]   sel;
  logic            rr_mode;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_sel;
  logic            out_valid;
  logic            out_ready;

  typedef struct packed {
    logic [SW-1:0] s;
    logic [W-1:0]  d;
  } word_t;

  word_t q[$];
  int    m_ptr;
  int    n_vec;
  int    n_err;
  bit    probe;

  mux_pipe #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .rr_mode(rr_mode), .out_data(out_data),
    .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic rand_data();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
  endtask

  task automatic step();
    int g;
    bit ok, can, acc, drn;
    logic [N-1:0] er;
    logic [N-1:0] r0;
    @(negedge clk);
    if (probe) begin
      r0 = in_ready;
      out_ready = ~out_ready;
      #1;
      n_vec++;
      if (in_ready !== r0) begin
        n_err++;
        $display("FAIL ready_indep: in_ready=%b expected %b", in_ready, r0);
      end
      out_ready = ~out_ready;
      #1;
    end
    g  = 0;
    ok = 1'b0;
    if (!rr_mode) begin
      g  = int'(sel);
      ok = (g < N);
    end else begin
      for (int i = 1; i <= N && !ok; i++) begin
        int c;
        c = (m_ptr + i) % N;
        if (in_valid[c]) begin
          g  = c;
          ok = 1'b1;
        end
      end
    end
    can = (q.size() < DEPTH) || (DEPTH == 1 && out_ready);
    er  = '0;
    if (ok && can) er[g] = 1'b1;
    n_vec++;
    if (in_ready !== er) begin
      n_err++;
      $display("FAIL in_ready: got %b expected %b", in_ready, er);
    end
    n_vec++;
    if (out_valid !== (q.size() != 0)) begin
      n_err++;
      $display("FAIL out_valid: got %b expected %b", out_valid, q.size() != 0);
    end
    if (q.size() != 0) begin
      n_vec++;
      if (out_data !== q[0].d || out_sel !== q[0].s) begin
        n_err++;
        $display("FAIL out_word: got sel=%0d data=%h expected sel=%0d data=%h",
                 out_sel, out_data, q[0].s, q[0].d);
      end
    end
    acc = ok && can && in_valid[g];
    drn = (q.size() != 0) && out_ready;
    @(posedge clk);
    if (drn) void'(q.pop_front());
    if (acc) begin
      q.push_back('{s: SW'(g), d: in_data[g*W +: W]});
      if (rr_mode) m_ptr = g;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = '0; in_data = '0; sel = '0; rr_mode = 1'b0; out_ready = 1'b0;
    #3;
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== '0) begin
      n_err++;
      $display("FAIL reset_state: valid=%b data=%h sel=%0d expected 0/0/0", out_valid, out_data, out_sel);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    m_ptr = N - 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_explicit();
    rr_mode = 1'b0; sel = 2'd2; in_valid = '1; out_ready = 1'b1;
    rand_data();
    in_data[2*W +: W] = 32'h00000022;
    #1;
    n_vec++;
    if (in_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL explicit_ready: got %b expected 0100", in_ready);
    end
    step();
    n_vec++;
    if (out_data !== 32'h22 || out_sel !== 2'd2 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL explicit_out: data=%h sel=%0d valid=%b expected 22/2/1", out_data, out_sel, out_valid);
    end
    for (int k = 0; k < 40; k++) begin
      sel = SW'($urandom_range(N - 1));
      in_valid = N'($urandom);
      out_ready = 1'($urandom);
      rand_data();
      step();
    end
  endtask

  task automatic test_reset_mid_transfer();
    rr_mode = 1'b0; sel = '0; in_valid = 4'b0001; out_ready = 1'b1;
    rand_data();
    in_data[0 +: W] = 32'hDEADBEEF;
    step();
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL mid_setup: valid=%b data=%h expected 1/deadbeef", out_valid, out_data);
    end
    in_valid = '0; out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      n_err++;
      $display("FAIL async_reset: valid=%b data=%h expected 0/0", out_valid, out_data);
    end
    q.delete();
    m_ptr = N - 1;
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL post_reset_pulse: valid=%b expected 0", out_valid);
      end
    end
  endtask

  task automatic test_rr_fairness();
    rr_mode = 1'b1; in_valid = '1; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      rand_data();
      step();
      n_vec++;
      if (out_valid !== 1'b1 || out_sel !== SW'(k % N)) begin
        n_err++;
        $display("FAIL rr_order: step %0d valid=%b sel=%0d expected 1/%0d", k, out_valid, out_sel, k % N);
      end
    end
  endtask

  task automatic test_sparse();
    logic [SW-1:0] exp_s [4];
    exp_s = '{2'd3, 2'd1, 2'd3, 2'd1};
    rr_mode = 1'b1; out_ready = 1'b1; in_valid = 4'b0010;
    rand_data();
    step();
    in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      rand_data();
      step();
      n_vec++;
      if (out_sel !== exp_s[k]) begin
        n_err++;
        $display("FAIL sparse_grant: step %0d sel=%0d expected %0d", k, out_sel, exp_s[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0]  hd;
    logic [SW-1:0] hs;
    rr_mode = 1'b0; sel = 2'd1; in_valid = '1; out_ready = 1'b1;
    rand_data();
    step();
    hd = out_data; hs = out_sel;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rand_data();
      sel = SW'($urandom_range(N - 1));
      step();
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== hd || out_sel !== hs) begin
        n_err++;
        $display("FAIL stall_hold: valid=%b data=%h sel=%0d expected 1/%h/%0d", out_valid, out_data, out_sel, hd, hs);
      end
    end
    out_ready = 1'b1;
    rand_data();
    step();
    n_vec++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL drain_reload: valid=%b expected 1", out_valid);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      rr_mode = 1'($urandom);
      sel = SW'($urandom_range(N - 1));
      in_valid = N'($urandom);
      out_ready = ($urandom_range(3) != 0);
      rand_data();
      step();
    end
  endtask

`ifdef MUX_PIPE_SKID_EN
  task automatic test_skid_toggle();
    rr_mode = 1'b1; in_valid = '1; out_ready = 1'b0;
    probe = 1'b1;
    for (int k = 0; k < 60; k++) begin
      out_ready = ~out_ready;
      rand_data();
      step();
    end
    probe = 1'b0;
  endtask
`endif

  initial begin
    n_vec = 0; n_err = 0; probe = 1'b0; m_ptr = N - 1;
    test_reset();
    test_explicit();
    test_reset_mid_transfer();
    test_rr_fairness();
    test_sparse();
    test_backpressure();
    test_random();
`ifdef MUX_PIPE_SKID_EN
    test_skid_toggle();
`endif
    in_valid = '0; out_ready = 1'b1;
    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
